round_pack: RTL
===============

// Module: round_pack
// PURPOSE
// - Post-normalization stage of the shared FP32 / dual-FP16 add datapath. Sits directly downstream of the normalizer.
// - Takes the normalized 28-bit fraction, per-lane LZC counts and pre-normalization exponents.
// - Computes final exponents, rounds to nearest-even, handles overflow/underflow/specials, packs one FP32 or two 16-bit lanes.
// - Registered 2-stage pipeline with valid/ready backpressure.
// PARAMETERS
// - EXP_W  10  width of signed two's-complement biased exponent inputs (bias 127, 8-bit field in both formats)
// PORTS
// - clk         in   1   clock
// - rst_n       in   1   asynchronous, active-low reset
// - in_valid    in   1   input beat valid
// - in_ready    out  1   stage can accept a beat
// - in_fmt      in   fp_fmt_e  FP32 = single lane; otherwise dual 16-bit lanes (hi/lo)
// - in_frac     in   28  normalized fraction from normalizer R
// - in_count_h  in   5   hi-lane LZC (full 28-bit LZC in FP32)
// - in_count_l  in   5   lo-lane LZC (FP16 only; ignored in FP32)
// - in_exp_h    in   EXP_W  hi/FP32 exponent before normalization
// - in_exp_l    in   EXP_W  lo exponent before normalization (FP16 only)
// - in_sign_h/l in   1   lane sign
// - in_nan_h/l  in   1   lane result is NaN (forces output regardless of frac)
// - in_inf_h/l  in   1   lane result is infinity
// - out_valid   out  1   result valid
// - out_ready   in   1   consumer accepts result
// - out_result  out  32  FP32 {s,e8,m23}, or {hi16,lo16} with each lane {s,e8,m7}
// - out_flags   out  6   {of_h,uf_h,nx_h,of_l,uf_l,nx_l}; lo bits 0 in FP32
// BEHAVIOUR
// - Reset: out_valid=0, out_result=0, out_flags=0, both stage-valid regs 0; in_ready=1 after reset.
//   Asynchronous: a reset mid-operation drops all in-flight beats immediately.
// - Field extraction:
//   - FP32: leading bit frac[27], mantissa frac[26:4], guard frac[3], sticky |frac[2:0].
//   - FP16 hi: lead frac[27], mant frac[26:20], guard frac[19], sticky |frac[18:14].
//   - FP16 lo: lead frac[11], mant frac[10:4], guard frac[3], sticky |frac[2:0]; frac[13:12] ignored.
// - Exponent: e = in_exp + 1 - count (signed EXP_W). RNE: inc = guard & (sticky | mant[0]).
//   - Mantissa carry-out: mant=0, e=e+1.
//   - nx = guard | sticky.
// - Lead bit 0 (exact cancellation): +0, no flags.
// - e >= 255 after rounding: {sign, 8'hFF, 0}, of=1, nx=1.
// - e <= 0 after rounding: flush to {sign, 0, 0}, uf=1, nx=1.
// - nan: canonical quiet NaN (FP32 0x7FC00000, lane 0x7FC0), no flags.
//   inf (nan clear): {sign, 8'hFF, 0}, no flags.
// - Pipeline:
//   - S1 registers per-lane {sign, e, mant, inc, flags, special}; S2 registers packed result = outputs.
//   - Latency exactly 2 cycles from in_valid&in_ready to out_valid when unstalled; throughput 1 beat/cycle.
//   - Each stage loads when empty or its content advances in the same cycle. in_ready = !s1_v | (s2 advances | !s2_v).
//   - out_valid && !out_ready holds out_result/out_flags stable. At most 2 beats buffered; strict in-order.
//   - Simultaneous input accept and output drain in the same cycle must not lose or duplicate a beat.
// - fmt travels with each beat; mixed-fmt back-to-back beats are legal.
// TESTING
// - FP32 frac=28'h8000000, count_h=0, exp_h=127, sign 0 -> out_result=32'h40000000, flags 0, 2 cycles later.
// - FP32 frac=28'hFFFFFF8, count_h=0, exp_h=127 -> tie odd rounds up with carry -> 32'h40800000, nx_h=1.
// - FP16x2 frac={14'h2000,14'h0800}, counts 0, exp_h=127, exp_l=126 -> 32'h40003F80, flags 0.
// - FP32 frac=28'h8000000, exp_h=254 -> 32'h7F800000, of_h=1, nx_h=1; exp_h=-1 -> 32'h00000000, uf_h=1.
// - Hold out_ready=0 while pushing 3 beats: in_ready drops after 2 accepted, out_result stable; release -> 3 beats in order.
// - Assert rst_n=0 with 2 beats in flight -> out_valid=0 asynchronously; no stale beat appears after release.

Source files
------------

// File: rtl/round_pack.sv
// Rounding/packing stage of the shared FP32 / dual-FP16 adder: exponent fix-up,
// round-to-nearest-even, overflow/underflow/special handling, 2-stage valid/ready pipe.
package round_pack_pkg;
  typedef enum logic {FMT_FP32 = 1'b0, FMT_FP16X2 = 1'b1} fp_fmt_e;
  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} lane_kind_e;
  typedef struct packed {
    logic [31:0] bits;
    logic [2:0]  flags;
  } lane_res_t;
endpackage

module round_pack
  import round_pack_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_fmt_e          in_fmt,
  input  logic [27:0]      in_frac,
  input  logic [4:0]       in_count_h,
  input  logic [4:0]       in_count_l,
  input  logic [EXP_W-1:0] in_exp_h,
  input  logic [EXP_W-1:0] in_exp_l,
  input  logic             in_sign_h,
  input  logic             in_sign_l,
  input  logic             in_nan_h,
  input  logic             in_nan_l,
  input  logic             in_inf_h,
  input  logic             in_inf_l,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [5:0]       out_flags
);

  // Two guard bits keep exp+1-count and the rounding carry free of wrap-around.
  localparam int E2 = EXP_W + 2;
  localparam logic signed [E2-1:0] E_ONE  = 1;
  localparam logic signed [E2-1:0] E_MAX  = 255;
  localparam logic signed [E2-1:0] E_ZERO = 0;

  typedef struct packed {
    logic                 sign;
    logic signed [E2-1:0] e;
    logic [22:0]          mant;
    logic                 inc;
    logic                 nx;
    lane_kind_e           kind;
  } lane_t;

  // FP16 lanes keep their 7-bit mantissa left-aligned in the 23-bit field.
  function automatic lane_t mk_lane(input logic sign, input logic nan, input logic inf,
                                    input logic lead, input logic [22:0] mant,
                                    input logic lsb, input logic guard, input logic sticky,
                                    input logic [EXP_W-1:0] exp_in, input logic [4:0] cnt);
    lane_t                ln;
    logic signed [E2-1:0] ex;
    logic signed [E2-1:0] cx;
    ex      = {{2{exp_in[EXP_W-1]}}, exp_in};
    cx      = {{(E2-5){1'b0}}, cnt};
    ln.sign = sign;
    ln.e    = ex + E_ONE - cx;
    ln.mant = mant;
    ln.inc  = guard & (sticky | lsb);
    ln.nx   = guard | sticky;
    if (nan)       ln.kind = K_NAN;
    else if (inf)  ln.kind = K_INF;
    else if (!lead) ln.kind = K_ZERO;
    else           ln.kind = K_NORM;
    return ln;
  endfunction

  function automatic lane_res_t round_lane(input lane_t ln, input logic fp16);
    lane_res_t            r;
    logic [23:0]          sum;
    logic                 carry;
    logic signed [E2-1:0] er;
    sum   = {1'b0, ln.mant} + (ln.inc ? (fp16 ? 24'h010000 : 24'h000001) : 24'h000000);
    carry = sum[23];
    er    = ln.e + {{(E2-1){1'b0}}, carry};
    r     = '0;
    case (ln.kind)
      K_NAN:  r.bits = 32'h7FC00000;
      K_INF:  r.bits = {ln.sign, 8'hFF, 23'h0};
      K_ZERO: r.bits = 32'h0;
      default: begin
        if (er >= E_MAX) begin
          r.bits  = {ln.sign, 8'hFF, 23'h0};
          r.flags = 3'b101;
        end else if (er <= E_ZERO) begin
          r.bits  = {ln.sign, 31'h0};
          r.flags = 3'b011;
        end else begin
          r.bits  = {ln.sign, er[7:0], carry ? 23'h0 : sum[22:0]};
          r.flags = {2'b00, ln.nx};
        end
      end
    endcase
    return r;
  endfunction

  logic      fp16_in;
  lane_t     d_h, d_l;
  logic      s1_v, s2_v, s1_load, s2_load;
  fp_fmt_e   s1_fmt;
  lane_t     s1_h, s1_l;
  lane_res_t res_h, res_l;
  logic      s1_fp16;
  logic [31:0] pack_result;
  logic [5:0]  pack_flags;
  logic      unused_bits;

  assign fp16_in = (in_fmt == FMT_FP16X2);

  assign d_h = mk_lane(in_sign_h, in_nan_h, in_inf_h, in_frac[27],
                       fp16_in ? {in_frac[26:20], 16'h0} : in_frac[26:4],
                       fp16_in ? in_frac[20] : in_frac[4],
                       fp16_in ? in_frac[19] : in_frac[3],
                       fp16_in ? |in_frac[18:14] : |in_frac[2:0],
                       in_exp_h, in_count_h);

  assign d_l = mk_lane(in_sign_l, in_nan_l, in_inf_l, in_frac[11],
                       {in_frac[10:4], 16'h0}, in_frac[4], in_frac[3], |in_frac[2:0],
                       in_exp_l, in_count_l);

  assign s1_fp16 = (s1_fmt == FMT_FP16X2);
  assign res_h   = round_lane(s1_h, s1_fp16);
  assign res_l   = round_lane(s1_l, 1'b1);

  assign pack_result = s1_fp16 ? {res_h.bits[31:16], res_l.bits[31:16]} : res_h.bits;
  assign pack_flags  = s1_fp16 ? {res_h.flags, res_l.flags} : {res_h.flags, 3'b000};

  assign unused_bits = ^{in_frac[13:12], res_l.bits[15:0]};

  assign in_ready  = ~s1_v | ~s2_v | out_ready;
  assign s1_load   = in_valid & in_ready;
  assign s2_load   = s1_v & (~s2_v | out_ready);
  assign out_valid = s2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      s1_fmt     <= FMT_FP32;
      s1_h       <= '0;
      s1_l       <= '0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      s1_v <= s1_load | (s1_v & ~s2_load);
      s2_v <= s2_load | (s2_v & ~out_ready);
      if (s1_load) begin
        s1_fmt <= in_fmt;
        s1_h   <= d_h;
        s1_l   <= d_l;
      end
      if (s2_load) begin
        out_result <= pack_result;
        out_flags  <= pack_flags;
      end
    end
  end

endmodule
